// File: rtl/sram_dma_engine_if.sv
// sram_dma_engine_if
//   Purpose: the single-port SRAM bus between the DMA engine (the initiator) and
//   the data SRAM.
//   Signals:
//     Address    [ADDR_W]  SRAM address              (engine -> SRAM)
//     SRAMRead             read strobe               (engine -> SRAM)
//     SRAMWrite            write strobe              (engine -> SRAM)
//     Datain     [DATA_W]  write data                (engine -> SRAM)
//     Dataout    [DATA_W]  read data, valid the cycle after the read edge
//                                                    (SRAM -> engine)
//   Modports: master = engine side, slave = SRAM side.
interface sram_dma_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] Address;
    logic              SRAMRead;
    logic              SRAMWrite;
    logic [DATA_W-1:0] Datain;
    logic [DATA_W-1:0] Dataout;

    modport master (
        output Address, SRAMRead, SRAMWrite, Datain,
        input  Dataout
    );

    modport slave (
        input  Address, SRAMRead, SRAMWrite, Datain,
        output Dataout
    );
endinterface

// File: rtl/sram_dma_engine.sv
// sram_dma_engine
//   Purpose: initiator side of the single-port SRAM. It accepts one copy or fill
//   command and then sequences the SRAM accesses one byte at a time. A copy
//   moves length bytes from src_addr to dst_addr (read, then write, per byte,
//   strictly ascending). A fill writes fill_data into length bytes at dst_addr.
//   Addresses wrap modulo 2**ADDR_W. Lengths above 2**ADDR_W saturate.
//   Ports:
//     clk        rising-edge clock
//     Reset      asynchronous, active-high reset; aborts a running command
//                without a done pulse
//     start      command strobe, only sampled while idle
//     mode       0 = copy, 1 = fill (captured with start)
//     src_addr   copy source base (captured with start)
//     dst_addr   destination base (captured with start)
//     length     byte count 0..2**ADDR_W (captured with start)
//     fill_data  fill byte (captured with start)
//     busy       high while a command is in progress
//     done       one-cycle pulse when a command completes
//     count      bytes written so far. It holds after done until the next start.
//     sram       SRAM bus (master modport)
module sram_dma_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     length,
    input  logic [DATA_W-1:0]    fill_data,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     count,
    sram_dma_engine_if.master    sram
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t              state;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   fill_q;
    logic                mode_q;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    idx_next;
    logic [LEN_W-1:0]    len_sat;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_q;
    logic                wr_q;

    assign idx_next = idx + LEN_W'(1);
    assign len_sat  = (length > MAX_LEN) ? MAX_LEN : length;

    assign sram.Address   = addr_q;
    assign sram.SRAMRead  = rd_q;
    assign sram.SRAMWrite = wr_q;

    // In copy mode the write data is the SRAM's own read register. It is valid
    // during the WR cycle and is held there because WR issues no read. So it is
    // passed straight through. Registering it would cost an extra cycle per
    // byte. The write strobe gates the data, so Datain is 0 whenever no write
    // is in progress, and also during reset.
    assign sram.Datain = wr_q ? (mode_q ? fill_q : sram.Dataout) : '0;

    // Command sequencer. The strobes, Address, busy and done for the next
    // cycle are registered here alongside the state transition.
    // A zero-length command goes to FIN with busy still high. FIN then spends
    // one cycle dropping busy and raising done. A command that made writes
    // reaches FIN with done already raised, so FIN only clears done and
    // returns to IDLE.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            fill_q <= '0;
            mode_q <= 1'b0;
            idx    <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len_sat;
                        fill_q <= fill_data;
                        mode_q <= mode;
                        idx    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        if (len_sat == '0) begin
                            state <= FIN;
                        end else if (!mode) begin
                            state  <= RD;
                            rd_q   <= 1'b1;
                            addr_q <= src_addr;
                        end else begin
                            state  <= WR;
                            wr_q   <= 1'b1;
                            addr_q <= dst_addr;
                        end
                    end
                end

                RD: begin
                    state  <= WR;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b1;
                    addr_q <= dst_q + idx[ADDR_W-1:0];
                end

                WR: begin
                    idx   <= idx_next;
                    count <= count + LEN_W'(1);
                    wr_q  <= 1'b0;
                    if (idx_next == len_q) begin
                        state  <= FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        addr_q <= '0;
                    end else if (!mode_q) begin
                        state  <= RD;
                        rd_q   <= 1'b1;
                        addr_q <= src_q + idx_next[ADDR_W-1:0];
                    end else begin
                        state  <= WR;
                        wr_q   <= 1'b1;
                        addr_q <= dst_q + idx_next[ADDR_W-1:0];
                    end
                end

                FIN: begin
                    rd_q <= 1'b0;
                    wr_q <= 1'b0;
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
